// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter among N byte-stream requesters. Ownership is
//   granted for a whole message. A message ends when a byte with LAST is sent,
//   or when the owner leaves REQ low for Timeout cycles. Ownership rotates
//   round-robin between messages. While a requester owns the line, the block
//   drives the UART's DIN/OE strobe for it and returns a one-cycle ACK per
//   accepted byte, so messages are never interleaved on the line.
//
// Ports:
//   CLK     in   1         system clock (single domain, shared with the UART)
//   RST     in   1         synchronous reset, active-high
//   REQ     in   N         per-requester byte-valid, held until ACK
//   LAST    in   N         per-requester end-of-message flag, qualified by REQ
//   DATA    in   N*Wdata   requester i's byte at [i*Wdata +: Wdata]
//   ACK     out  N         one-cycle pulse: owner's byte accepted by the UART
//   GNT     out  N         one-hot current owner (registered), zero when idle
//   TX_DIN  out  Wdata     byte to the UART transmitter
//   TX_OE   out  1         transmit strobe to the UART transmitter
//   TX_RDY  in   1         UART transmitter ready/idle
//
// Parameters:
//   N        number of requesters (2..8)
//   Wdata    bits per byte, must match the UART
//   Timeout  cycles of owner REQ low in SEND before forced release (1..255)
// ============================================================================
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int Wdata   = 8,
    parameter int Timeout = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         LAST,
    input  logic [N*Wdata-1:0]   DATA,
    output logic [N-1:0]         ACK,
    output logic [N-1:0]         GNT,
    output logic [Wdata-1:0]     TX_DIN,
    output logic                 TX_OE,
    input  logic                 TX_RDY
);

    localparam int              IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]      TMO = 8'(Timeout);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_GUARD   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [7:0]      tmo_q,   tmo_d;
    logic            last_q,  last_d;

    // ------------------------------------------------------------------
    // Owner-side views of the requester buses. The registered one-hot
    // grant selects the owner's REQ/LAST/DATA, so non-owners can never
    // leak into the handshake.
    // ------------------------------------------------------------------
    logic [N-1:0][Wdata-1:0] data_masked;
    logic [Wdata-1:0]        own_data;
    logic                    own_req;
    logic                    own_last;

    for (genvar gi = 0; gi < N; gi++) begin : g_data_mask
        assign data_masked[gi] = gnt_q[gi] ? DATA[gi*Wdata +: Wdata] : '0;
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            own_data = own_data | data_masked[i];
        end
    end

    assign own_req  = |(REQ  & gnt_q);
    assign own_last = |(LAST & gnt_q);

    // ------------------------------------------------------------------
    // Round-robin pick. REQ is rotated so that bit k corresponds to
    // requester (ptr + k) mod N; the lowest set bit of the rotated vector
    // is the winner. Doubling REQ makes the rotation a plain part-select.
    // ------------------------------------------------------------------
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   first_hit;
    logic [IW-1:0]  pick_idx;

    assign req_dbl = {REQ, REQ};
    assign rot_req = req_dbl[{1'b0, ptr_q} +: N];

    for (genvar gi = 0; gi < N; gi++) begin : g_first_hit
        // A rotated position wins only if no lower rotated position requests.
        localparam logic [N-1:0] LOWER_MASK = N'((1 << gi) - 1);
        assign first_hit[gi] = rot_req[gi] & ~|(rot_req & LOWER_MASK);
    end

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (first_hit[k]) begin
                pick_idx = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit handshake. A byte moves in the cycle TX_OE is high, which
    // can only happen in SEND with the UART ready and the owner requesting.
    // ------------------------------------------------------------------
    logic tx_oe;

    assign tx_oe  = (state_q == S_SEND) && TX_RDY && own_req;
    assign TX_OE  = tx_oe;
    assign TX_DIN = (state_q == S_SEND) ? own_data : '0;
    assign ACK    = tx_oe ? gnt_q : '0;
    assign GNT    = gnt_q;

    // Saturating increment: the counter never wraps back below Timeout.
    logic [7:0] tmo_inc;
    assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        tmo_d   = tmo_q;
        last_d  = last_q;

        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (|REQ) begin
                    owner_d = pick_idx;
                    gnt_d   = N'(1) << pick_idx;
                    tmo_d   = '0;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_oe) begin
                    last_d  = own_last;
                    tmo_d   = '0;
                    state_d = S_GUARD;
                end else if (!own_req) begin
                    // Owner went quiet mid-message; give up the line once
                    // it has been silent for Timeout cycles.
                    tmo_d = tmo_inc;
                    if (tmo_inc >= TMO) begin
                        gnt_d   = '0;
                        state_d = S_RELEASE;
                    end
                end
            end

            // The UART drops RDY one cycle after the strobe, so RDY seen
            // here would still be the stale "ready" from before the byte.
            S_GUARD: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (TX_RDY) begin
                    if (last_q) begin
                        gnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end

            S_RELEASE: begin
                gnt_d   = '0;
                ptr_d   = IW'((int'(owner_q) + 1) % N);
                tmo_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter
//
// Requester queues drive REQ/LAST/DATA and pop a byte on ACK. A simple UART
// model drops RDY one cycle after each strobe for busy_len cycles. Each test
// pushes the expected line order into exp_q; a monitor pops and compares on
// every TX_OE, and the main thread adds a few cycle-exact GNT checks.
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   REQ;
    logic [N-1:0]   LAST;
    logic [N*W-1:0] DATA;
    logic [N-1:0]   ACK;
    logic [N-1:0]   GNT;
    logic [W-1:0]   TX_DIN;
    logic           TX_OE;
    logic           TX_RDY;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.N(N), .Wdata(W), .Timeout(T)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .LAST   (LAST),
        .DATA   (DATA),
        .ACK    (ACK),
        .GNT    (GNT),
        .TX_DIN (TX_DIN),
        .TX_OE  (TX_OE),
        .TX_RDY (TX_RDY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- UART model ----------------
    int busy_len  = 0;
    bit force_low = 1'b0;
    int busy_cnt  = 0;
    bit fall_pend = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            busy_cnt  <= 0;
            fall_pend <= 1'b0;
        end else begin
            fall_pend <= TX_OE;
            if (fall_pend)
                busy_cnt <= busy_len;
            else if (busy_cnt > 0)
                busy_cnt <= busy_cnt - 1;
        end
    end

    assign TX_RDY = !force_low && (busy_cnt == 0);

    // ---------------- Requester model ----------------
    logic [8:0] rmem [N][32];
    int         rhead [N];
    int         rtail [N];

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (rhead[i] < rtail[i]) begin
                REQ[i]          = 1'b1;
                LAST[i]         = rmem[i][rhead[i]][8];
                DATA[i*W +: W]  = rmem[i][rhead[i]][7:0];
            end else begin
                REQ[i]          = 1'b0;
                LAST[i]         = 1'b0;
                DATA[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic push_byte(input int r, input bit is_last, input logic [7:0] d);
        rmem[r][rtail[r]] = {is_last, d};
        rtail[r]++;
        refresh();
    endtask

    logic [11:0] exp_q [$];

    task automatic expect_xfer(input int r, input logic [7:0] d);
        exp_q.push_back({4'(r), d});
    endtask

    initial begin
        logic [N-1:0] ack_s;
        forever begin
            @(negedge CLK);
            ack_s = ACK;
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_s[i] && rhead[i] < rtail[i]) rhead[i]++;
            end
            refresh();
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    initial begin
        logic [11:0]  e;
        logic [N-1:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_gnt = '0;
            end else begin
                if (TX_OE) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got data 0x%02h ack %b, required no transfer", TX_DIN, ACK);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer owner=%0d data=0x%02h ack=%b gnt=%b", e[11:8], TX_DIN, ACK, GNT);
                        chk("xfer_data", 32'(TX_DIN), 32'(e[7:0]));
                        chk("xfer_ack",  32'(ACK),    32'(1) << e[11:8]);
                        chk("xfer_gnt",  32'(GNT),    32'(1) << e[11:8]);
                    end
                end else begin
                    chk("ack_without_oe", 32'(ACK), 32'h0);
                end
                if (prev_gnt != '0 && GNT != '0)
                    chk("gnt_stable", 32'(GNT), 32'(prev_gnt));
                prev_gnt = GNT;
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic clear_queues();
        for (int i = 0; i < N; i++) rhead[i] = rtail[i];
        exp_q.delete();
        refresh();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_queues();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int c    = 0;
        bit done = 1'b0;
        while (!done && c < max_cyc) begin
            @(negedge CLK);
            c++;
            done = (exp_q.size() == 0) && (REQ == '0) && (GNT == '0);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done: %0d transfers outstanding after %0d cycles, required 0",
                     name, exp_q.size(), max_cyc);
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        REQ  = '0;
        LAST = '0;
        DATA = '0;
        RST  = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_gnt",    32'(GNT),    32'h0);
        chk("reset_ack",    32'(ACK),    32'h0);
        chk("reset_tx_oe",  32'(TX_OE),  32'h0);
        chk("reset_tx_din", 32'(TX_DIN), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Test 1: single-byte message from requester 1.
        busy_len = 0;
        push_byte(1, 1'b1, 8'h41);
        expect_xfer(1, 8'h41);
        @(negedge CLK);
        chk("t1_gnt",   32'(GNT),    32'h2);
        chk("t1_oe",    32'(TX_OE),  32'h1);
        chk("t1_din",   32'(TX_DIN), 32'h41);
        chk("t1_ack",   32'(ACK),    32'h2);
        @(negedge CLK);
        chk("t1_guard_gnt", 32'(GNT), 32'h2);
        repeat (2) @(negedge CLK);
        chk("t1_release_gnt", 32'(GNT), 32'h0);
        wait_done("t1", 50);

        // Test 2: all four request single-byte messages, slow UART.
        do_reset();
        busy_len = 10;
        push_byte(0, 1'b1, 8'hA0);
        push_byte(0, 1'b1, 8'hA4);
        push_byte(1, 1'b1, 8'hA1);
        push_byte(2, 1'b1, 8'hA2);
        push_byte(3, 1'b1, 8'hA3);
        expect_xfer(0, 8'hA0);
        expect_xfer(1, 8'hA1);
        expect_xfer(2, 8'hA2);
        expect_xfer(3, 8'hA3);
        expect_xfer(0, 8'hA4);
        wait_done("t2", 1000);

        // Test 3: 3-byte message from 2 is not interleaved with 0 (pointer=1).
        busy_len = 3;
        push_byte(2, 1'b0, 8'h10);
        push_byte(2, 1'b0, 8'h11);
        push_byte(2, 1'b1, 8'h12);
        push_byte(0, 1'b1, 8'h55);
        expect_xfer(2, 8'h10);
        expect_xfer(2, 8'h11);
        expect_xfer(2, 8'h12);
        expect_xfer(0, 8'h55);
        wait_done("t3", 500);

        // Test 4: owner 3 goes quiet after one byte; forced release after T.
        busy_len = 0;
        push_byte(3, 1'b0, 8'h33);
        expect_xfer(3, 8'h33);
        @(negedge CLK);
        chk("t4_gnt_c1", 32'(GNT), 32'h8);
        push_byte(1, 1'b1, 8'h71);
        expect_xfer(1, 8'h71);
        // SEND, GUARD, WAIT, then 16 quiet SEND cycles: held through cycle 19.
        for (int k = 2; k <= 3 + T; k++) begin
            @(negedge CLK);
            chk("t4_gnt_held", 32'(GNT), 32'h8);
        end
        @(negedge CLK);
        chk("t4_gnt_released", 32'(GNT), 32'h0);
        repeat (2) @(negedge CLK);
        chk("t4_gnt_next", 32'(GNT), 32'h2);
        wait_done("t4", 100);

        // Test 5: UART not ready while owner 2 holds REQ.
        force_low = 1'b1;
        push_byte(2, 1'b1, 8'h5A);
        expect_xfer(2, 8'h5A);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            chk("t5_oe_blocked",  32'(TX_OE), 32'h0);
            chk("t5_ack_blocked", 32'(ACK),   32'h0);
            chk("t5_gnt",         32'(GNT),   32'h4);
        end
        @(posedge CLK);
        #1;
        force_low = 1'b0;
        @(negedge CLK);
        chk("t5_oe",  32'(TX_OE),  32'h1);
        chk("t5_ack", 32'(ACK),    32'h4);
        chk("t5_din", 32'(TX_DIN), 32'h5A);
        @(negedge CLK);
        chk("t5_single_oe", 32'(TX_OE), 32'h0);
        wait_done("t5", 100);

        // Test 6: reset in WAIT mid-message, then pointer is back at 0.
        busy_len = 10;
        push_byte(1, 1'b0, 8'h81);
        push_byte(1, 1'b1, 8'h82);
        expect_xfer(1, 8'h81);
        repeat (3) @(negedge CLK);
        chk("t6_wait_gnt", 32'(GNT), 32'h2);
        RST = 1'b1;
        clear_queues();
        @(negedge CLK);
        chk("t6_rst_gnt", 32'(GNT),   32'h0);
        chk("t6_rst_oe",  32'(TX_OE), 32'h0);
        chk("t6_rst_ack", 32'(ACK),   32'h0);
        RST = 1'b0;
        @(negedge CLK);
        push_byte(0, 1'b1, 8'h90);
        push_byte(3, 1'b1, 8'h93);
        expect_xfer(0, 8'h90);
        expect_xfer(3, 8'h93);
        @(negedge CLK);
        chk("t6_winner", 32'(GNT), 32'h1);
        wait_done("t6", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
